// File: rtl/uart_link_ctrl_if.sv
// rtl/uart_link_ctrl_if.sv - byte-level UART handshake bundle between link controller and UART
interface uart_link_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       rx_clear;
  logic [7:0] tx_data;
  logic       tx_wr_en;
  logic       tx_busy;

  modport master (
    input  rx_data, rx_ready, tx_busy,
    output rx_clear, tx_data, tx_wr_en
  );

  modport slave (
    output rx_data, rx_ready, tx_busy,
    input  rx_clear, tx_data, tx_wr_en
  );
endinterface

// File: rtl/uart_link_ctrl.sv
// rtl/uart_link_ctrl.sv - host link: header assembly with idle resync, nonce queue and MSB-first TX
// Optional trailing XOR checksum byte per frame when UART_LINK_CHECKSUM_EN is defined.
module uart_link_ctrl #(
  parameter int HEADER_BYTES   = 80,
  parameter int NONCE_BYTES    = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      clock,
  input  logic                      reset,
  uart_link_ctrl_if.master          uart,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic                      frame_error,
  input  logic [NONCE_BYTES*8-1:0]  nonce_in,
  input  logic                      nonce_push,
  output logic                      fifo_full,
  output logic                      overflow
);
  localparam int HW = HEADER_BYTES * 8;
  localparam int NW = NONCE_BYTES * 8;
`ifdef UART_LINK_CHECKSUM_EN
  localparam int FRAME_BYTES = HEADER_BYTES + 1;
`else
  localparam int FRAME_BYTES = HEADER_BYTES;
`endif
  localparam int CW   = $clog2(FRAME_BYTES + 1);
  localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int BW   = $clog2(NONCE_BYTES + 1);

  // ---------------- RX frame assembly ----------------
  logic          rx_accept;
  logic          last_byte;
  logic          idle_expired;
  logic [CW-1:0] rx_count;
  logic [IW-1:0] idle_count;
  logic [HW-1:0] assembly;
`ifdef UART_LINK_CHECKSUM_EN
  logic [7:0]    rx_xor;
`endif

  // The clear pulse masks the flag for one cycle so a still-high rx_ready is not taken twice.
  assign rx_accept    = uart.rx_ready && !uart.rx_clear;
  assign last_byte    = (rx_count == CW'(FRAME_BYTES - 1));
  assign idle_expired = (idle_count == IW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      uart.rx_clear <= 1'b0;
      header_valid  <= 1'b0;
      frame_error   <= 1'b0;
      header_data   <= '0;
      assembly      <= '0;
      rx_count      <= '0;
      idle_count    <= '0;
`ifdef UART_LINK_CHECKSUM_EN
      rx_xor        <= '0;
`endif
    end else begin
      uart.rx_clear <= rx_accept;
      header_valid  <= 1'b0;
      frame_error   <= 1'b0;
      if (rx_accept) begin
        idle_count <= '0;
        if (last_byte) begin
          rx_count <= '0;
`ifdef UART_LINK_CHECKSUM_EN
          rx_xor <= '0;
          if (uart.rx_data == rx_xor) begin
            header_data  <= assembly;
            header_valid <= 1'b1;
          end else begin
            frame_error <= 1'b1;
          end
`else
          header_data  <= {assembly[HW-9:0], uart.rx_data};
          header_valid <= 1'b1;
`endif
        end else begin
          rx_count <= rx_count + CW'(1);
          assembly <= {assembly[HW-9:0], uart.rx_data};
`ifdef UART_LINK_CHECKSUM_EN
          rx_xor   <= rx_xor ^ uart.rx_data;
`endif
        end
      end else if (rx_count != '0) begin
        if (idle_expired) begin
          rx_count    <= '0;
          idle_count  <= '0;
          frame_error <= 1'b1;
`ifdef UART_LINK_CHECKSUM_EN
          rx_xor      <= '0;
`endif
        end else begin
          idle_count <= idle_count + IW'(1);
        end
      end
    end
  end

  // ---------------- nonce queue ----------------
  logic [NW-1:0]   fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CNTW-1:0] fifo_count, count_next;
  logic            push, pop;

  assign push = nonce_push && !fifo_full;

  always_comb begin
    count_next = fifo_count + CNTW'(push) - CNTW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= nonce_in;
        wr_ptr           <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= count_next;
      fifo_full  <= (count_next == CNTW'(FIFO_DEPTH));
      if (nonce_push && fifo_full)
        overflow <= 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT_BUSY, TX_WAIT_DONE} tx_state_t;
  tx_state_t     state, state_next;
  logic [NW-1:0] shift;
  logic [BW-1:0] bytes_left;
  logic          tx_fire, shift_en;

  always_ff @(posedge clock) begin
    if (reset) state <= TX_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      TX_IDLE:      if (fifo_count != '0) state_next = TX_SEND;
      TX_SEND:      if (!uart.tx_busy)    state_next = TX_WAIT_BUSY;
      TX_WAIT_BUSY: if (uart.tx_busy)     state_next = TX_WAIT_DONE;
      TX_WAIT_DONE: if (!uart.tx_busy)
                      state_next = (bytes_left == BW'(1)) ? TX_IDLE : TX_SEND;
      default:      state_next = TX_IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    tx_fire  = 1'b0;
    shift_en = 1'b0;
    case (state)
      TX_IDLE:      pop      = (fifo_count != '0);
      TX_SEND:      tx_fire  = !uart.tx_busy;
      TX_WAIT_DONE: shift_en = !uart.tx_busy;
      default: ;
    endcase
  end

  // Strobe and byte are registered together so tx_data is stable for the whole strobe.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift         <= '0;
      bytes_left    <= '0;
      uart.tx_data  <= '0;
      uart.tx_wr_en <= 1'b0;
    end else begin
      uart.tx_wr_en <= tx_fire;
      if (pop) begin
        shift      <= fifo_mem[rd_ptr];
        bytes_left <= BW'(NONCE_BYTES);
      end
      if (tx_fire)
        uart.tx_data <= shift[NW-1 -: 8];
      if (shift_en) begin
        shift      <= shift << 8;
        bytes_left <= bytes_left - BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_uart_link_ctrl.sv
// tb/tb_uart_link_ctrl.sv - directed table-driven bench for uart_link_ctrl (4-byte header/nonce, depth 2)
module tb_uart_link_ctrl;
  localparam int HB = 4;
  localparam int NB = 4;
  localparam int FD = 2;
  localparam int TO = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  uart_link_ctrl_if u_if ();

  logic [HB*8-1:0] header_data;
  logic            header_valid, frame_error, fifo_full, overflow;
  logic [NB*8-1:0] nonce_in   = '0;
  logic            nonce_push = 1'b0;
  logic            tx_busy_m  = 1'b0;

  assign u_if.tx_busy = tx_busy_m;

  uart_link_ctrl #(
    .HEADER_BYTES(HB), .NONCE_BYTES(NB), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset), .uart(u_if),
    .header_data(header_data), .header_valid(header_valid), .frame_error(frame_error),
    .nonce_in(nonce_in), .nonce_push(nonce_push),
    .fifo_full(fifo_full), .overflow(overflow)
  );

  int tests = 0;
  int fails = 0;

  int hv_cnt = 0, fe_cnt = 0, clr_cnt = 0, strobe_viol = 0;
  int pend = 0, bcnt = 0;
  logic [7:0] txq[$];

  // Pulse monitor plus UART TX model: busy rises one cycle after a strobe, for 10 cycles.
  always @(negedge clock) begin
    if (header_valid) hv_cnt++;
    if (frame_error) fe_cnt++;
    if (u_if.rx_clear) clr_cnt++;
    if (u_if.tx_wr_en) begin
      txq.push_back(u_if.tx_data);
      if (tx_busy_m) strobe_viol++;
    end
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) tx_busy_m = 1'b0;
    end else if (pend != 0) begin
      pend = 0;
      tx_busy_m = 1'b1;
      bcnt = 10;
    end
    if (u_if.tx_wr_en) pend = 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int lat;
    lat = 0;
    u_if.rx_data  = b;
    u_if.rx_ready = 1'b1;
    do begin
      cyc(1);
      lat++;
    end while (!u_if.rx_clear && lat < 20);
    check("rx_clear_latency", lat, 1);
    u_if.rx_ready = 1'b0;
    cyc(1);
  endtask

  task automatic push_nonce(input logic [31:0] v);
    nonce_in   = v;
    nonce_push = 1'b1;
    cyc(1);
    nonce_push = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int bound);
    int t;
    t = 0;
    while (txq.size() < n && t < bound) begin
      cyc(1);
      t++;
    end
    check("tx_byte_count", txq.size(), n);
  endtask

  typedef struct {
    int          nb;
    logic [31:0] data;
    int          idle;
    logic [7:0]  chk;
    bit          send_chk;
    logic [31:0] exp_hdr;
    int          exp_hv;
    int          exp_fe;
  } rx_vec_t;

  rx_vec_t vecs[5];

  initial begin
    int hv0, fe0, clr0, base, exp_clr;
    logic [31:0] d;
    logic [7:0] exp_a[4];
    logic [7:0] exp_b[12];

    vecs[0] = '{4, 32'hDEADBEEF, 4,  8'h22, 1'b1, 32'hDEADBEEF, 1, 0};
    vecs[1] = '{2, 32'h11220000, 20, 8'h00, 1'b0, 32'hDEADBEEF, 0, 1};
    vecs[2] = '{4, 32'hA1A2A3A4, 4,  8'h04, 1'b1, 32'hA1A2A3A4, 1, 0};
    vecs[3] = '{2, 32'h55660000, 8,  8'h00, 1'b0, 32'hA1A2A3A4, 0, 0};
    vecs[4] = '{2, 32'h77880000, 4,  8'hCC, 1'b1, 32'h55667788, 1, 0};
    exp_a = '{8'h12, 8'h34, 8'h56, 8'h78};
    exp_b = '{8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
              8'h1A, 8'h1B, 8'h1C, 8'h1D};

    u_if.rx_data  = 8'h00;
    u_if.rx_ready = 1'b0;
    cyc(3);
    reset = 1'b0;
    cyc(1);
    check("rst_header_data", header_data, 0);
    check("rst_header_valid", header_valid, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_wr_en", u_if.tx_wr_en, 0);
    check("rst_tx_data", u_if.tx_data, 0);
    check("rst_rx_clear", u_if.rx_clear, 0);

    for (int i = 0; i < 5; i++) begin
      hv0 = hv_cnt; fe0 = fe_cnt; clr0 = clr_cnt;
      d = vecs[i].data;
      exp_clr = vecs[i].nb;
      for (int k = 0; k < vecs[i].nb; k++)
        send_byte(d[31-8*k -: 8]);
`ifdef UART_LINK_CHECKSUM_EN
      if (vecs[i].send_chk) begin
        send_byte(vecs[i].chk);
        exp_clr++;
      end
`endif
      cyc(vecs[i].idle);
      check("vec_header_data", header_data, vecs[i].exp_hdr);
      check("vec_header_valid_pulses", hv_cnt - hv0, vecs[i].exp_hv);
      check("vec_frame_error_pulses", fe_cnt - fe0, vecs[i].exp_fe);
      check("vec_rx_clear_pulses", clr_cnt - clr0, exp_clr);
    end

`ifdef UART_LINK_CHECKSUM_EN
    hv0 = hv_cnt; fe0 = fe_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08); send_byte(8'h0F);
    cyc(4);
    check("chk_good_header", header_data, 32'h01020408);
    check("chk_good_valid", hv_cnt - hv0, 1);
    check("chk_good_error", fe_cnt - fe0, 0);
    hv0 = hv_cnt; fe0 = fe_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h04); send_byte(8'h08); send_byte(8'h00);
    cyc(4);
    check("chk_bad_header", header_data, 32'h01020408);
    check("chk_bad_valid", hv_cnt - hv0, 0);
    check("chk_bad_error", fe_cnt - fe0, 1);
`endif

    // Single nonce, MSB first.
    base = txq.size();
    push_nonce(32'h12345678);
    wait_tx(base + 4, 200);
    for (int i = 0; i < 4; i++)
      if (base + i < txq.size()) check("tx_single_byte", txq[base+i], exp_a[i]);
    cyc(20);

    // Queue fill while the serialiser is occupied: third push is dropped.
    base = txq.size();
    push_nonce(32'hCAFEF00D);
    wait_tx(base + 1, 50);
    nonce_in = 32'h0A0B0C0D; nonce_push = 1'b1;
    cyc(1);
    check("full_after_push1", fifo_full, 0);
    nonce_in = 32'h1A1B1C1D;
    cyc(1);
    check("full_after_push2", fifo_full, 1);
    check("overflow_before_drop", overflow, 0);
    nonce_in = 32'hEEEEEEEE;
    cyc(1);
    nonce_push = 1'b0;
    check("overflow_after_drop", overflow, 1);
    check("full_after_drop", fifo_full, 1);
    wait_tx(base + 12, 600);
    for (int i = 0; i < 12; i++)
      if (base + i < txq.size()) check("tx_burst_byte", txq[base+i], exp_b[i]);
    cyc(40);
    check("tx_dropped_not_sent", txq.size(), base + 12);
    check("overflow_sticky", overflow, 1);
    check("full_after_drain", fifo_full, 0);
    check("strobe_only_when_idle", strobe_viol, 0);

    // Reset in the middle of a nonce with another queued behind it.
    base = txq.size();
    push_nonce(32'h12345678);
    push_nonce(32'h55AA55AA);
    wait_tx(base + 2, 100);
    if (base + 1 < txq.size()) check("tx_before_reset", txq[base+1], 8'h34);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("post_rst_overflow", overflow, 0);
    check("post_rst_fifo_full", fifo_full, 0);
    check("post_rst_header_data", header_data, 0);
    check("post_rst_tx_wr_en", u_if.tx_wr_en, 0);
    cyc(100);
    check("post_rst_no_tx", txq.size(), base + 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
